rj_loader: RTL and testbench

Upstream write sequencer for the MSDAP rj memory. It deserializes 16-bit words from the serial input line and writes them into consecutive rj memory addresses. It also runs a clear sweep that zeroes every location. It drives the memory's level-sensitive enable/write/clear interface with a strict request/release handshake, and it reports completion and error status to the main controller.

---
 rtl/rj_loader.sv | 191 +++++++++++++++++++
 tb/tb_rj_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rj_loader.sv
// rj_loader: write sequencer for the MSDAP rj memory.
//   Deserializes 16-bit MSB-first words from the serial line and writes them to consecutive
//   rj addresses. It also runs a clear sweep that zeroes every location. Each memory access uses
//   a request/release handshake on mem_en/mem_w_done, and each wait is bounded by a timeout.
// Parameters:
//   WORDS     words per load or clear sequence (1..16); the last address is WORDS-1
//   WAIT_MAX  cycles allowed for mem_w_done to rise (request) or fall (release)
// Ports:
//   sclk, reset_n              clock, asynchronous active-low reset
//   load_start, clear_start    one-cycle start requests, accepted only when idle
//   frame, data_bit            serial word strobe (high with bit 15) and data
//   mem_w_done                 write-done flag from the memory
//   mem_en, mem_wr             memory request, write-select
//   mem_cntrl_rst              zero the addressed location
//   mem_wr_addr, mem_data      target address and write data
//   busy, done, err            status: not idle, sequence complete, sticky error
module rj_loader #(
   parameter int unsigned WORDS    = 16,
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        sclk,
   input  logic        reset_n,
   input  logic        load_start,
   input  logic        clear_start,
   input  logic        frame,
   input  logic        data_bit,
   input  logic        mem_w_done,
   output logic        mem_en,
   output logic        mem_wr,
   output logic        mem_cntrl_rst,
   output logic [3:0]  mem_wr_addr,
   output logic [15:0] mem_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // Timer runs 0..WAIT_MAX-1; the wait expires on the cycle it would reach WAIT_MAX.
   localparam int unsigned TimerW   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [TimerW-1:0] TmoLast = TimerW'(WAIT_MAX - 1);
   localparam logic [3:0]        LastAddr = 4'(WORDS - 1);

   typedef enum logic [2:0] {
      StIdle, StLoadRx, StWrReq, StWrRel, StClrReq, StClrRel
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        addr_q, addr_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [14:0]       shift_q, shift_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;   // bits still expected; 0 = not receiving
   logic [15:0]       hold_q, hold_d;
   logic              full_q, full_d;

   logic        start, abort, full_clr, rx_err, rx_on, tmo;
   logic [15:0] word;

   assign tmo   = (timer_q == TmoLast);
   assign rx_on = (state_q == StLoadRx) || (state_q == StWrReq) || (state_q == StWrRel);

   // Sequencer: handshake, address walk and timeout.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      timer_d  = '0;
      done_d   = done_q;
      start    = 1'b0;
      abort    = 1'b0;
      full_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clear_start) begin
               state_d = StClrReq;
               start   = 1'b1;
            end else if (load_start) begin
               state_d = StLoadRx;
               start   = 1'b1;
            end
         end
         StLoadRx: begin
            if (full_q) state_d = StWrReq;
         end
         StWrReq, StClrReq: begin
            if (mem_w_done) begin
               state_d  = (state_q == StWrReq) ? StWrRel : StClrRel;
               full_clr = (state_q == StWrReq);
            end else if (tmo) begin
               abort = 1'b1;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         StWrRel, StClrRel: begin
            if (!mem_w_done) begin
               if (addr_q == LastAddr) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = (state_q == StWrRel) ? StLoadRx : StClrReq;
                  addr_d  = addr_q + 4'd1;
               end
            end else if (tmo) begin
               abort = 1'b1;
            end else begin
               timer_d = timer_q + TimerW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
      if (start) done_d = 1'b0;
      if (abort) begin
         state_d = StIdle;
         done_d  = 1'b0;
      end
      // Idle always parks at address 0 so a new sequence (or an abort) starts clean.
      if (state_d == StIdle) addr_d = '0;
   end

   // Deserializer feeding the single-entry holding register.
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      hold_d    = hold_q;
      full_d    = full_q & ~full_clr;
      rx_err    = 1'b0;
      word      = {shift_q, data_bit};
      if (!rx_on) begin
         bit_cnt_d = '0;
         full_d    = 1'b0;
      end else if (frame) begin
         // A frame inside a word discards the partial word and restarts on this one.
         rx_err    = (bit_cnt_q != 4'd0);
         shift_d   = {14'd0, data_bit};
         bit_cnt_d = 4'd15;
      end else if (bit_cnt_q != 4'd0) begin
         shift_d   = word[14:0];
         bit_cnt_d = bit_cnt_q - 4'd1;
         if (bit_cnt_q == 4'd1) begin
            // A word released in this same cycle frees the slot, so it is not an overrun.
            if (full_d) begin
               rx_err = 1'b1;
            end else begin
               hold_d = word;
               full_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      err_d = start ? 1'b0 : err_q;
      if (abort || rx_err) err_d = 1'b1;
   end

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         timer_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         hold_q    <= '0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         timer_q   <= timer_d;
         done_q    <= done_d;
         err_q     <= err_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         hold_q    <= hold_d;
         full_q    <= full_d;
      end
   end

   // Memory outputs decode straight from registered state, so they never glitch.
   assign mem_en        = (state_q == StWrReq) || (state_q == StClrReq);
   assign mem_wr        = (state_q == StWrReq);
   assign mem_cntrl_rst = (state_q == StClrReq);
   assign mem_wr_addr   = addr_q;
   assign mem_data      = mem_wr ? hold_q : 16'd0;
   assign busy          = (state_q != StIdle);
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_rj_loader.sv
// tb_rj_loader: directed sequence with random words/delays for rj_loader, checked against a
// behavioural memory model and per-scenario expected contents.
module tb_rj_loader;

   localparam int unsigned WORDS   = 16;
   localparam int unsigned TB_WAIT = 31;

   logic        sclk = 1'b0;
   logic        reset_n, load_start, clear_start, frame, data_bit, mem_w_done;
   logic        mem_en, mem_wr, mem_cntrl_rst, busy, done, err;
   logic [3:0]  mem_wr_addr;
   logic [15:0] mem_data;

   rj_loader #(
      .WORDS    (WORDS),
      .WAIT_MAX (TB_WAIT)
   ) dut (
      .sclk          (sclk),
      .reset_n       (reset_n),
      .load_start    (load_start),
      .clear_start   (clear_start),
      .frame         (frame),
      .data_bit      (data_bit),
      .mem_w_done    (mem_w_done),
      .mem_en        (mem_en),
      .mem_wr        (mem_wr),
      .mem_cntrl_rst (mem_cntrl_rst),
      .mem_wr_addr   (mem_wr_addr),
      .mem_data      (mem_data),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] data;
      logic        wr;
      logic        rst;
   } wr_t;

   wr_t         log_q[$];
   logic [15:0] mem_m [16];
   logic [15:0] words [17];
   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   bit          hold_low = 1'b0;
   bit          ovr_mode = 1'b0;
   bit          rnd_dly  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      repeat (gap) begin
         frame    = 1'b0;
         data_bit = 1'($urandom);
         tick();
      end
      for (int i = 15; i >= 0; i--) begin
         frame    = (i == 15);
         data_bit = w[i];
         tick();
      end
      frame    = 1'b0;
      data_bit = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      check(tag, done, 1);
   endtask

   task automatic wait_log(input int n, input int budget, input string tag);
      int k = 0;
      while (log_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(tag, log_q.size(), n);
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic load_seq(input int n, input bit rnd_gap);
      log_q.delete();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("start_busy", busy, 1);
      check("start_done_cleared", done, 0);
      for (int k = 0; k < n; k++) send_word(words[k], rnd_gap ? int'($urandom_range(0, 3)) : 0);
      wait_done(60, "load_done");
   endtask

   // Memory responder: raises w_done after a delay while requested, drops it on release.
   initial begin
      int          cnt = 0;
      int          dly = 2;
      bit          prev_en = 1'b0;
      logic [3:0]  cap_addr;
      logic [15:0] cap_data;
      mem_w_done = 1'b0;
      forever begin
         @(posedge sclk);
         #2;
         if (!reset_n) begin
            mem_w_done = 1'b0;
            cnt        = 0;
            prev_en    = 1'b0;
         end else begin
            if (mem_en && !prev_en) check("en_rise_wdone_low", mem_w_done, 0);
            if (mem_en && !mem_w_done) begin
               if (cnt == 0) begin
                  cap_addr = mem_wr_addr;
                  cap_data = mem_data;
                  if (ovr_mode && mem_wr_addr == 4'd3 && mem_data == 16'hA5A5) dly = 20;
                  else if (rnd_dly) dly = int'($urandom_range(2, 8));
                  else dly = 2;
               end else begin
                  check("req_addr_stable", mem_wr_addr, cap_addr);
                  check("req_data_stable", mem_data, cap_data);
               end
               cnt++;
               if (!hold_low && cnt >= dly) begin
                  mem_w_done = 1'b1;
                  mem_m[mem_wr_addr] = mem_wr ? mem_data : 16'h0000;
                  log_q.push_back('{addr: mem_wr_addr, data: mem_data, wr: mem_wr,
                                    rst: mem_cntrl_rst});
               end
            end else if (!mem_en) begin
               mem_w_done = 1'b0;
               cnt        = 0;
            end
            prev_en = mem_en;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0; load_start = 1'b0; clear_start = 1'b0; frame = 1'b0; data_bit = 1'b0;
      for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
      #3;
      check("reset_outputs", {mem_en, mem_wr, mem_cntrl_rst, mem_wr_addr, mem_data, busy, done, err},
            0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      // Frames while idle are ignored.
      send_word(16'hDEAD, 0);
      tick();
      check("idle_frame_err", err, 0);
      check("idle_frame_busy", busy, 0);
      check("idle_frame_writes", log_q.size(), 0);

      // Nominal load 0x0001..0x0010.
      for (int k = 0; k < 16; k++) words[k] = 16'(k + 1);
      load_seq(16, 1'b0);
      check("nom_writes", log_q.size(), 16);
      for (int i = 0; i < log_q.size(); i++) check($sformatf("nom_addr%0d", i), log_q[i].addr, i);
      for (int i = 0; i < 16; i++) check($sformatf("nom_mem%0d", i), mem_m[i], i + 1);
      check("nom_err", err, 0);
      check("nom_busy", busy, 0);

      // Random words, random frame gaps and random memory latency.
      rnd_dly = 1'b1;
      for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
      load_seq(16, 1'b1);
      rnd_dly = 1'b0;
      for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), mem_m[i], words[i]);
      check("rnd_err", err, 0);

      // Clear sweep; clear wins over a simultaneous load.
      for (int i = 0; i < 16; i++) mem_m[i] = 16'hFFFF;
      log_q.delete();
      clear_start = 1'b1;
      load_start  = 1'b1;
      tick();
      clear_start = 1'b0;
      load_start  = 1'b0;
      check("clr_first_rst", mem_cntrl_rst, 1);
      check("clr_first_wr", mem_wr, 0);
      wait_done(200, "clr_done");
      check("clr_writes", log_q.size(), 16);
      for (int i = 0; i < log_q.size(); i++) begin
         check($sformatf("clr_addr%0d", i), log_q[i].addr, i);
         check($sformatf("clr_wr%0d", i), log_q[i].wr, 0);
         check($sformatf("clr_rst%0d", i), log_q[i].rst, 1);
      end
      for (int i = 0; i < 16; i++) check($sformatf("clr_mem%0d", i), mem_m[i], 0);
      check("clr_err", err, 0);
      check("clr_busy", busy, 0);

      // Overrun: slow write of 0xA5A5 at address 3 drops the following word.
      for (int k = 0; k < 17; k++) begin
         words[k] = 16'($urandom);
         if (words[k] == 16'hA5A5) words[k] = 16'h5A5A;
      end
      words[3] = 16'hA5A5;
      ovr_mode = 1'b1;
      load_seq(17, 1'b0);
      ovr_mode = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 17; k++) if (k != 4) exp_q.push_back(words[k]);
      check("ovr_writes", log_q.size(), 16);
      for (int i = 0; i < log_q.size(); i++) begin
         check($sformatf("ovr_addr%0d", i), log_q[i].addr, i);
         check($sformatf("ovr_data%0d", i), log_q[i].data, exp_q[i]);
      end
      check("ovr_err", err, 1);

      // Framing error: frame re-asserted at bit 8 restarts the word.
      log_q.delete();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("frm_err_cleared", err, 0);
      frame = 1'b1; data_bit = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         frame = 1'b0; data_bit = 1'b1;
         tick();
      end
      send_word(16'h1234, 0);
      check("frm_err", err, 1);
      repeat (20) tick();
      check("frm_writes", log_q.size(), 1);
      if (log_q.size() > 0) begin
         check("frm_data", log_q[0].data, 16'h1234);
         check("frm_addr", log_q[0].addr, 0);
      end

      // Reset while a request is outstanding at address 1.
      pulse_reset();
      log_q.delete();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      send_word(16'h1111, 0);
      wait_log(1, 10, "rst_first_write");
      hold_low = 1'b1;
      send_word(16'h2222, 0);
      tick();
      check("rst_pre_en", mem_en, 1);
      check("rst_pre_addr", mem_wr_addr, 1);
      check("rst_pre_data", mem_data, 16'h2222);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async_outputs",
            {mem_en, mem_wr, mem_cntrl_rst, mem_wr_addr, mem_data, busy, done, err}, 0);
      tick();
      reset_n  = 1'b1;
      hold_low = 1'b0;
      log_q.delete();
      tick();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      send_word(16'h3333, 0);
      wait_log(1, 10, "rst_restart_write");
      if (log_q.size() > 0) begin
         check("rst_restart_addr", log_q[0].addr, 0);
         check("rst_restart_data", log_q[0].data, 16'h3333);
      end

      // Timeout: w_done never answers.
      pulse_reset();
      hold_low   = 1'b1;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      send_word(16'h5A5A, 0);
      check("tmo_en_before", mem_en, 0);
      tick();
      check("tmo_en_latency", mem_en, 1);
      begin
         int k = 0;
         while (err !== 1'b1 && k < int'(TB_WAIT) + 20) begin
            tick();
            k++;
         end
         check("tmo_cycles", k, TB_WAIT);
      end
      check("tmo_outputs", {mem_en, mem_wr, mem_cntrl_rst, mem_wr_addr, mem_data, busy, done}, 0);
      hold_low = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
